// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// lane-shift constants and request-classification helpers.
package lsu_pkg;

  localparam int unsigned ADDR_LIMIT_DEF = 1024;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Big-endian lanes: lower byte address lives in the more significant bits.
  localparam logic [4:0] SHIFT_HALF_HI = 5'd16;
  localparam logic [4:0] SHIFT_HALF_LO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } lsu_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
    misaligned = ((op[1:0] == SIZE_HALF) && lane[0]) ||
                 ((op[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request bus between the MEM stage and the LSU, and the LSU-to-data-memory bus.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] load_data;
  logic        done;
  logic        err;

  modport master (output req_valid, req_op, req_addr, req_wdata,
                  input  req_ready, load_data, done, err);
  modport slave  (input  req_valid, req_op, req_addr, req_wdata,
                  output req_ready, load_data, done, err);
endinterface

interface lsu_mem_if;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] mem_read_data;

  modport master (output mem_address, mem_write_data, MemWrite, MemRead,
                  input  mem_read_data);
  modport slave  (input  mem_address, mem_write_data, MemWrite, MemRead,
                  output mem_read_data);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: sub-word load extract/extend and sub-word store
// merge into a previously read memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_shift;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  always_comb begin
    // Byte shift is (3 - lane) * 8, i.e. the inverted lane index times 8.
    w_shift   = (i_op[1:0] == SIZE_HALF) ? (i_lane[1] ? SHIFT_HALF_LO : SHIFT_HALF_HI)
                                         : {~i_lane, 3'b000};
    w_shifted = i_word >> w_shift;
    o_load    = i_word;
    w_mask    = 32'hFFFF_FFFF;
    w_ins     = i_wdata;
    case (i_op[1:0])
      SIZE_BYTE: begin
        o_load = {{24{w_shifted[7] & ~i_op[2]}}, w_shifted[7:0]};
        w_mask = 32'h0000_00FF << w_shift;
        w_ins  = {24'b0, i_wdata[7:0]} << w_shift;
      end
      SIZE_HALF: begin
        o_load = {{16{w_shifted[15] & ~i_op[2]}}, w_shifted[15:0]};
        w_mask = 32'h0000_FFFF << w_shift;
        w_ins  = {16'b0, i_wdata[15:0]} << w_shift;
      end
      default: ;
    endcase
    o_merge = (i_word & ~w_mask) | w_ins;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the MEM stage and a 256x32 synchronous data
// memory; sub-word stores are done as read-modify-write.
//   state | meaning
//   IDLE  | ready; accepts a request, flags errors immediately
//   RD    | MemRead high, memory samples address at the next edge
//   CAP   | read word valid: finish load or merge store data
//   WR    | MemWrite high, done follows at the next edge
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input logic       Clk,
  input logic       Rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [3:0]  r_op;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        w_accept;
  logic        w_bad;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_accept = req.req_valid && (r_state == ST_IDLE);
  assign w_bad    = !op_legal(req.req_op) || misaligned(req.req_op, req.req_addr[1:0]) ||
                    (req.req_addr >= ADDR_LIMIT);

  lsu_lane_align u_align (
    .i_op   (r_op),
    .i_lane (r_lane),
    .i_word (mem.mem_read_data),
    .i_wdata(r_wdata),
    .o_load (w_load),
    .o_merge(w_merge)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_bad) w_next = (req.req_op == OP_SW) ? ST_WR : ST_RD;
      ST_RD:   w_next = ST_CAP;
      ST_CAP:  w_next = r_op[3] ? ST_WR : ST_IDLE;
      ST_WR:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_op        <= '0;
      r_lane      <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= req.req_op;
          r_lane  <= req.req_addr[1:0];
          r_wdata <= req.req_wdata;
          if (w_bad) begin
            r_done      <= 1'b1;
            r_err       <= 1'b1;
            r_load_data <= '0;
          end else begin
            r_mem_addr <= req.req_addr[9:2];
            if (req.req_op == OP_SW) begin
              r_mem_write <= 1'b1;
              r_mem_wdata <= req.req_wdata;
            end else begin
              r_mem_read  <= 1'b1;
            end
          end
        end
        ST_CAP: begin
          if (r_op[3]) begin
            r_mem_write <= 1'b1;
            r_mem_wdata <= w_merge;
          end else begin
            r_load_data <= w_load;
            r_done      <= 1'b1;
          end
        end
        ST_WR:   r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign req.req_ready      = (r_state == ST_IDLE);
  assign req.load_data      = r_load_data;
  assign req.done           = r_done;
  assign req.err            = r_err;
  assign mem.mem_address    = {24'b0, r_mem_addr};
  assign mem.mem_write_data = r_mem_wdata;
  assign mem.MemRead        = r_mem_read;
  assign mem.MemWrite       = r_mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256x32 synchronous memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic Clk;
  logic Rst_n;
  int   checks = 0;
  int   errors = 0;

  lsu_req_if req_if ();
  lsu_mem_if mem_if ();

  load_store_unit #(.ADDR_LIMIT(1024)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .req  (req_if.slave),
    .mem  (mem_if.master)
  );

  logic [31:0] mem [0:255];

  always @(posedge Clk) begin
    if (mem_if.MemWrite) mem[mem_if.mem_address[7:0]] <= mem_if.mem_write_data;
    if (mem_if.MemRead)  mem_if.mem_read_data <= mem[mem_if.mem_address[7:0]];
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issue one request; lat = interval index of done after the accept edge
  // (0 = E0-E1), wr_at = first interval with MemWrite high.
  task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output int rd_n, output int wr_n, output int wr_at);
    req_if.req_op    = op;
    req_if.req_addr  = addr;
    req_if.req_wdata = wd;
    req_if.req_valid = 1'b1;
    @(posedge Clk);
    #1 req_if.req_valid = 1'b0;
    lat = -1; rd_n = 0; wr_n = 0; wr_at = -1;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      @(negedge Clk);
      if (mem_if.MemRead) rd_n++;
      if (mem_if.MemWrite) begin
        wr_n++;
        if (wr_at < 0) wr_at = k;
      end
      if (req_if.done) lat = k;
    end
  endtask

  int lat, rd_n, wr_n, wr_at, n_w, n_d;
  logic [3:0]  e_op   [4];
  logic [31:0] e_addr [4];

  initial begin
    Rst_n = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_op    = '0;
    req_if.req_addr  = '0;
    req_if.req_wdata = '0;
    #2;
    chk_b("rst_memread", mem_if.MemRead, 1'b0);
    chk_b("rst_memwrite", mem_if.MemWrite, 1'b0);
    chk_b("rst_done", req_if.done, 1'b0);
    chk_b("rst_err", req_if.err, 1'b0);
    chk_b("rst_ready", req_if.req_ready, 1'b1);
    chk("rst_load_data", req_if.load_data, 32'h0);
    chk("rst_mem_address", mem_if.mem_address, 32'h0);
    chk("rst_mem_wdata", mem_if.mem_write_data, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;

    run_req(OP_SW, 32'h14, 32'h8040_20FF, lat, rd_n, wr_n, wr_at);
    chk("sw_lat", lat, 1);
    chk("sw_wr_at", wr_at, 0);
    chk("sw_wr_n", wr_n, 1);
    chk("sw_rd_n", rd_n, 0);
    chk_b("sw_err", req_if.err, 1'b0);

    run_req(OP_LB, 32'h14, 32'h0, lat, rd_n, wr_n, wr_at);
    chk("lb_lat", lat, 2);
    chk("lb_rd_n", rd_n, 1);
    chk("lb_wr_n", wr_n, 0);
    chk("lb_data", req_if.load_data, 32'hFFFF_FF80);
    chk("lb_mem_address", mem_if.mem_address, 32'd5);
    chk_b("lb_err", req_if.err, 1'b0);

    run_req(OP_LBU, 32'h17, 32'h0, lat, rd_n, wr_n, wr_at);
    chk("lbu_lat", lat, 2);
    chk("lbu_data", req_if.load_data, 32'h0000_00FF);

    run_req(OP_LH, 32'h16, 32'h0, lat, rd_n, wr_n, wr_at);
    chk("lh_lat", lat, 2);
    chk("lh_data", req_if.load_data, 32'h0000_20FF);

    run_req(OP_LW, 32'h14, 32'h0, lat, rd_n, wr_n, wr_at);
    chk("lw_lat", lat, 2);
    chk("lw_data", req_if.load_data, 32'h8040_20FF);

    run_req(OP_SB, 32'h15, 32'h1234_56AB, lat, rd_n, wr_n, wr_at);
    chk("sb_lat", lat, 3);
    chk("sb_wr_at", wr_at, 2);
    chk("sb_rd_n", rd_n, 1);
    chk("sb_wr_n", wr_n, 1);
    chk("sb_load_hold", req_if.load_data, 32'h8040_20FF);
    chk("sb_word", mem[5], 32'h80AB_20FF);

    run_req(OP_SH, 32'h16, 32'h0000_BEEF, lat, rd_n, wr_n, wr_at);
    chk("sh_lat", lat, 3);
    chk("sh_word", mem[5], 32'h80AB_BEEF);

    run_req(OP_LW, 32'h14, 32'h0, lat, rd_n, wr_n, wr_at);
    chk("lw2_data", req_if.load_data, 32'h80AB_BEEF);
    run_req(OP_LH, 32'h14, 32'h0, lat, rd_n, wr_n, wr_at);
    chk("lh2_data", req_if.load_data, 32'hFFFF_80AB);

    e_op   = '{OP_LW, OP_SH, OP_LB, 4'b0111};
    e_addr = '{32'h02, 32'h03, 32'h400, 32'h00};
    for (int i = 0; i < 4; i++) begin
      run_req(e_op[i], e_addr[i], 32'hFFFF_FFFF, lat, rd_n, wr_n, wr_at);
      chk($sformatf("err%0d_lat", i), lat, 0);
      chk_b($sformatf("err%0d_err", i), req_if.err, 1'b1);
      chk($sformatf("err%0d_rd_n", i), rd_n, 0);
      chk($sformatf("err%0d_wr_n", i), wr_n, 0);
      chk($sformatf("err%0d_data", i), req_if.load_data, 32'h0);
    end
    chk("err_word_intact", mem[0], mem[0] === 32'hFFFF_FFFF ? 32'h0 : mem[0]);

    // Back-to-back: SW then LW with req_valid held through the SW done cycle.
    req_if.req_op    = OP_SW;
    req_if.req_addr  = 32'h20;
    req_if.req_wdata = 32'hDEAD_BEEF;
    req_if.req_valid = 1'b1;
    @(posedge Clk);
    #1 req_if.req_op = OP_LW;
    @(negedge Clk);
    chk_b("b2b_e0_done", req_if.done, 1'b0);
    chk_b("b2b_e0_memwrite", mem_if.MemWrite, 1'b1);
    chk_b("b2b_e0_ready", req_if.req_ready, 1'b0);
    @(negedge Clk);
    chk_b("b2b_sw_done", req_if.done, 1'b1);
    chk_b("b2b_ready", req_if.req_ready, 1'b1);
    @(posedge Clk);
    #1 req_if.req_valid = 1'b0;
    chk_b("b2b_lw_memread", mem_if.MemRead, 1'b1);
    lat = -1;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      @(negedge Clk);
      if (req_if.done) lat = k;
    end
    chk("b2b_lw_lat", lat, 2);
    chk("b2b_lw_data", req_if.load_data, 32'hDEAD_BEEF);

    // Reset while MemRead is high drops the strobe immediately.
    req_if.req_op    = OP_LB;
    req_if.req_addr  = 32'h14;
    req_if.req_valid = 1'b1;
    @(posedge Clk);
    #1 req_if.req_valid = 1'b0;
    chk_b("rstrd_memread_before", mem_if.MemRead, 1'b1);
    Rst_n = 1'b0;
    #1;
    chk_b("rstrd_memread_after", mem_if.MemRead, 1'b0);
    chk_b("rstrd_ready", req_if.req_ready, 1'b1);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Reset during SB CAP: no write, no done, word unchanged.
    run_req(OP_SW, 32'h30, 32'h1111_1111, lat, rd_n, wr_n, wr_at);
    req_if.req_op    = OP_SB;
    req_if.req_addr  = 32'h31;
    req_if.req_wdata = 32'h0000_0055;
    req_if.req_valid = 1'b1;
    @(posedge Clk);
    #1 req_if.req_valid = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk_b("rstcap_memwrite", mem_if.MemWrite, 1'b0);
    n_w = 0; n_d = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (mem_if.MemWrite) n_w++;
      if (req_if.done) n_d++;
    end
    Rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (mem_if.MemWrite) n_w++;
      if (req_if.done) n_d++;
    end
    chk("rstcap_wr_pulses", n_w, 0);
    chk("rstcap_done_pulses", n_d, 0);
    chk_b("rstcap_ready", req_if.req_ready, 1'b1);
    chk("rstcap_word", mem[12], 32'h1111_1111);
    run_req(OP_LW, 32'h30, 32'h0, lat, rd_n, wr_n, wr_at);
    chk("rstcap_lw_lat", lat, 2);
    chk("rstcap_lw_data", req_if.load_data, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
